// File: rtl/mips_pkg.sv
// mips_pkg: shared PC-unit FSM encoding and PC increment constant
package mips_pkg;
  typedef enum logic {RUN = 1'b0, PENDING = 1'b1} pc_state_t;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register with beq/bne/j/jr redirect, stall-deferred pending target, flush/misalign pulses and saturating redirect count
module pc_branch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_en,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        misalign,
  output logic [15:0] taken_count
);
  pc_state_t   state, state_n;
  logic [31:0] pend_target, target, apply_target, pc_n;
  logic        pend_mis, tgt_mis, apply_mis, taken, redirect, apply, capture;
  assign pc_plus4 = pc + PC_INC;
  assign taken    = branch_en && (zero ^ branch_ne);
  assign redirect = jr_en || jump_en || taken;
  assign target   = jr_en   ? {jr_addr[31:2], 2'b00} :
                    jump_en ? {pc_plus4[31:28], jump_index, 2'b00} :
                              pc_plus4 + branch_offset;
  assign tgt_mis  = jr_en && (jr_addr[1:0] != 2'b00);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else     state <= state_n;
  always_comb
    state_n = (state == PENDING) ? (stall ? PENDING : RUN) : ((stall && redirect) ? PENDING : RUN);
  always_comb begin
    apply        = !stall && (state == PENDING || redirect);
    capture      = stall && redirect && state == RUN;
    apply_target = (state == PENDING) ? pend_target : target;
    apply_mis    = (state == PENDING) ? pend_mis : tgt_mis;
    pc_n         = stall ? pc : apply ? apply_target : pc_plus4;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc          <= RESET_PC;
      pend_target <= '0;
      pend_mis    <= 1'b0;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      taken_count <= '0;
    end else begin
      pc       <= pc_n;
      flush    <= apply;
      misalign <= apply && apply_mis;
      if (capture) begin
        pend_target <= target;
        pend_mis    <= tgt_mis;
      end
      if (apply && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
    end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: randomized + directed check of pc_branch_unit against a behavioural model
module tb_pc_branch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic        clk = 0, rst = 1, stall = 0, branch_en = 0, branch_ne = 0, zero = 0, jump_en = 0, jr_en = 0;
  logic [31:0] branch_offset = 0, jr_addr = 0, pc, pc_plus4;
  logic [25:0] jump_index = 0;
  logic        flush, misalign;
  logic [15:0] taken_count;
  int          errors = 0, checks = 0;
  pc_branch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en), .branch_ne(branch_ne), .zero(zero),
    .branch_offset(branch_offset), .jump_en(jump_en), .jump_index(jump_index), .jr_en(jr_en),
    .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .misalign(misalign),
    .taken_count(taken_count)
  );
  always #5 clk = ~clk;
  logic [31:0] m_pc, m_ptgt, m_tgt, m_apply_tgt;
  logic        m_have_pend, m_pmis, m_flush, m_mis, m_redirect, m_tmis, m_applied, m_apply_mis;
  int          m_cnt;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_pc = RST_PC; m_have_pend = 0; m_ptgt = 0; m_pmis = 0; m_flush = 0; m_mis = 0; m_cnt = 0;
    end else begin
      m_redirect = jr_en || jump_en || (branch_en && (zero != branch_ne));
      if (jr_en)        m_tgt = jr_addr & 32'hFFFF_FFFC;
      else if (jump_en) m_tgt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_index) * 4);
      else              m_tgt = m_pc + 32'd4 + branch_offset;
      m_tmis = jr_en && (jr_addr % 4 != 0);
      m_applied = 0;
      if (m_have_pend) begin
        if (!stall) begin m_applied = 1; m_apply_tgt = m_ptgt; m_apply_mis = m_pmis; m_have_pend = 0; end
      end else if (m_redirect) begin
        if (stall) begin m_have_pend = 1; m_ptgt = m_tgt; m_pmis = m_tmis; end
        else begin m_applied = 1; m_apply_tgt = m_tgt; m_apply_mis = m_tmis; end
      end
      if (m_applied) begin
        m_pc = m_apply_tgt;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (!stall) m_pc = m_pc + 32'd4;
      m_flush = m_applied;
      m_mis = m_applied && m_apply_mis;
    end
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e); end
  endtask
  always @(negedge clk) begin
    cmp("model_pc", pc, m_pc);
    cmp("model_pc_plus4", pc_plus4, m_pc + 32'd4);
    cmp("model_flush", 32'(flush), 32'(m_flush));
    cmp("model_misalign", 32'(misalign), 32'(m_mis));
    cmp("model_count", 32'(taken_count), 32'(m_cnt));
  end
  task automatic idle();
    stall = 0; branch_en = 0; branch_ne = 0; zero = 0; branch_offset = 0;
    jump_en = 0; jump_index = 0; jr_en = 0; jr_addr = 0;
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic jr_to(input logic [31:0] a, input logic s);
    idle(); stall = s; jr_en = 1; jr_addr = a; step();
  endtask
  task automatic beq(input logic z, input logic [31:0] off);
    idle(); branch_en = 1; zero = z; branch_offset = off; step();
  endtask
  initial begin
    idle();
    rst = 1;
    step(); step();
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_count", 32'(taken_count), 0);
    cmp("rst_flush", 32'(flush), 0);
    rst = 0;
    cmp("seq_pc0", pc, 32'h0);
    step(); cmp("seq_pc1", pc, 32'h4);
    step(); cmp("seq_pc2", pc, 32'h8);
    step(); cmp("seq_pc3", pc, 32'hC);
    cmp("seq_count", 32'(taken_count), 0);
    jr_to(32'h100, 0);
    cmp("jr100_pc", pc, 32'h100);
    beq(1, 32'hFFFF_FFF0);
    cmp("beq_taken_pc", pc, 32'hF4);
    cmp("beq_taken_flush", 32'(flush), 1);
    cmp("beq_taken_count", 32'(taken_count), 2);
    idle(); step();
    cmp("flush_one_cycle", 32'(flush), 0);
    jr_to(32'h100, 0);
    beq(0, 32'hFFFF_FFF0);
    cmp("beq_not_pc", pc, 32'h104);
    cmp("beq_not_flush", 32'(flush), 0);
    cmp("beq_not_count", 32'(taken_count), 3);
    jr_to(32'h0040_0000, 0);
    idle(); jump_en = 1; jump_index = 26'h100; branch_en = 1; zero = 1; branch_offset = 32'h40; step();
    cmp("jump_wins_pc", pc, 32'h400);
    cmp("jump_wins_count", 32'(taken_count), 5);
    jr_to(32'h1003, 1);
    cmp("stall1_pc", pc, 32'h400);
    cmp("stall1_flush", 32'(flush), 0);
    idle(); stall = 1; jump_en = 1; jump_index = 26'h3; step();
    cmp("stall2_pc", pc, 32'h400);
    beq(1, 32'h40);
    cmp("pend_pc", pc, 32'h1000);
    cmp("pend_misalign", 32'(misalign), 1);
    cmp("pend_flush", 32'(flush), 1);
    cmp("pend_count", 32'(taken_count), 6);
    idle(); step();
    cmp("misalign_one_cycle", 32'(misalign), 0);
    cmp("after_pend_pc", pc, 32'h1004);
    jr_to(32'hFFFF_FFFC, 0);
    idle(); step();
    cmp("wrap_pc", pc, 32'h0);
    jr_to(32'h200, 1);
    rst = 1; #2;
    cmp("async_rst_pc", pc, RST_PC);
    cmp("async_rst_count", 32'(taken_count), 0);
    @(negedge clk); rst = 0; #1;
    idle(); step();
    cmp("post_rst_pc", pc, 32'h4);
    cmp("post_rst_flush", 32'(flush), 0);
    for (int i = 0; i < 3000; i++) begin
      stall = $urandom_range(0, 9) < 3;
      branch_en = $urandom_range(0, 3) == 0;
      branch_ne = $urandom_range(0, 1) == 1;
      zero = $urandom_range(0, 1) == 1;
      branch_offset = $urandom;
      jump_en = $urandom_range(0, 7) == 0;
      jump_index = 26'($urandom);
      jr_en = $urandom_range(0, 7) == 0;
      jr_addr = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1; #2; rst = 0;
      end
      step();
    end
    idle(); jump_en = 1;
    for (int i = 0; i < 65540; i++) begin
      jump_index = 26'($urandom);
      step();
    end
    cmp("sat_count", 32'(taken_count), 32'hFFFF);
    idle(); step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port stall, input, 1 bit: hold the PC this cycle.
REQ-005 SHALL have port branch_en, input, 1 bit: the current instruction is a conditional branch.
REQ-006 SHALL have port branch_ne, input, 1 bit: 1 = bne, 0 = beq.
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag for the current instruction.
REQ-008 SHALL have port branch_offset, input, 32 bits: sign-extended immediate, already shifted left by 2.
REQ-009 SHALL have port jump_en, input, 1 bit: j/jal.
REQ-010 SHALL have port jump_index, input, 26 bits: jump instruction index field.
REQ-011 SHALL have port jr_en, input, 1 bit: jump-register.
REQ-012 SHALL have port jr_addr, input, 32 bits: register target.
REQ-013 SHALL have port pc, output, 32 bits: current PC (registered).
REQ-014 SHALL have port pc_plus4, output, 32 bits: pc + 4.
REQ-015 SHALL have port flush, output, 1 bit: registered; high for one cycle after a redirect is applied.
REQ-016 SHALL have port misalign, output, 1 bit: registered; high for one cycle after a jr with jr_addr[1:0] != 0 is applied.
REQ-017 SHALL have port taken_count, output, 16 bits: count of applied redirects, saturating.

Function
REQ-018 SHALL compute pc_plus4 combinationally as pc + 4 modulo 2^32.
REQ-019 SHALL compute branch target as pc_plus4 + branch_offset, modulo 2^32, with wrap-around and no overflow flag.
REQ-020 SHALL compute jump target as {pc_plus4[31:28], jump_index, 2'b00}.
REQ-021 SHALL compute jr target as {jr_addr[31:2], 2'b00}.
REQ-022 SHALL treat a branch as taken when branch_en && (zero ^ branch_ne).
REQ-023 SHALL form redirect = jr_en || jump_en || branch taken, with target priority jr > jump > branch.
REQ-024 SHALL implement FSM states RUN and PENDING.
REQ-025 In RUN with stall=0 and redirect=1: SHALL load the selected target into pc, assert flush next cycle, and increment taken_count.
REQ-026 In RUN with stall=0 and redirect=0: SHALL load pc_plus4 into pc.
REQ-027 In RUN with stall=1 and redirect=1: SHALL hold pc, capture the target (and misalign cause) into pending_target, and go to PENDING.
REQ-028 In RUN with stall=1 and redirect=0: SHALL hold pc.
REQ-029 In PENDING with stall=1: SHALL hold pc and ignore new redirects (first captured wins).
REQ-030 In PENDING with stall=0: SHALL load pending_target into pc regardless of current decision inputs, assert flush next cycle, increment taken_count, and return to RUN.
REQ-031 SHALL apply one-cycle latency from decision to pc update; flush and misalign lag that update by 0 cycles (asserted in the same cycle the new pc appears).
REQ-032 SHALL saturate taken_count at 16'hFFFF.

Reset
REQ-033 On rst=1, asynchronously: pc=RESET_PC, state=RUN, pending_target=0, flush=0, misalign=0, taken_count=0.
REQ-034 SHALL discard a pending redirect on reset asserted mid-PENDING.
REQ-035 SHALL perform its first pc update on the first rising edge after rst deasserts.

Structure
REQ-036 SHALL place the FSM state encoding (RUN, PENDING) and the PC increment constant 4 in shared package mips_pkg.
REQ-037 SHALL use no sub-modules other than the existing branch shifter upstream feeding branch_offset; a single module is natural.

Verification
REQ-038 Reset then 3 idle cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; taken_count=0.
REQ-039 pc=0x100, beq, zero=1, offset=0xFFFFFFF0 -> next pc=0xF4, flush=1 for one cycle, taken_count=1; same with zero=0 -> pc=0x104, flush=0.
REQ-040 pc=0x0040_0000, jump_en=1, jump_index=0x0000100, branch also taken -> pc=0x0000_0400 (jump wins).
REQ-041 jr_en=1, jr_addr=0x1003, stall=1 for 2 cycles then 0, new branch taken on release -> pc holds, then pc=0x1000, misalign=1, flush=1, branch ignored.
REQ-042 pc=0xFFFFFFFC, no redirect -> pc=0x0 (wrap); taken_count preset to 0xFFFF by forcing 65535 redirects -> stays 0xFFFF.
REQ-043 rst asserted while in PENDING -> pc=RESET_PC immediately, state RUN, no flush after release.
